multi_cycle_ctr: RTL and testbench

Multi-cycle control sequencer for the MIPS-subset datapath. It replaces the purely combinational opcode decode with a five-state FSM (FETCH, DECODE, EXEC, MEM, WB). The FSM time-shares one ALU and one unified memory port across the phases of each instruction and stalls on a memory ready handshake. It sits between the instruction register and the datapath muxes and enables, and it keeps a retired-instruction counter.

---
 rtl/mcc_pkg.sv | 117 +++++++++++
 rtl/multi_cycle_ctr_if.sv | 35 +++
 rtl/mcc_op_decode.sv | 35 +++
 rtl/multi_cycle_ctr.sv | 125 ++++++++++++
 tb/tb_multi_cycle_ctr.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, FSM states, mux codes, ALU codes.
// No logic of its own.
// ctl_decode maps (state, decoded opcode) to the datapath control word that the FSM registers.
package mcc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [3:0] ALU_R    = 4'b1111;
  localparam logic [3:0] ALU_ADDI = 4'b1110;
  localparam logic [3:0] ALU_ANDI = 4'b0010;
  localparam logic [3:0] ALU_ORI  = 4'b0011;
  localparam logic [3:0] ALU_XORI = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_MEM  = 4'b0001;
  localparam logic [3:0] ALU_BR   = 4'b0101;
  localparam logic [3:0] ALU_JMP  = 4'b0000;

  typedef struct packed {
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       legal;
    logic [3:0] alu_op;
    logic       ext_op;
    logic       alu_src_b;
  } op_flags_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       branch_eq;
    logic       branch_ne;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       ext_op;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       illegal_op;
  } ctl_t;

  // Moore control word for a state; FETCH ir_wr/pc_wr are later qualified by mem_ready.
  function automatic ctl_t ctl_decode(state_t st, op_flags_t f);
    ctl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_rd = 1'b1;
        c.ir_wr  = 1'b1;
        c.pc_wr  = 1'b1;
        c.pc_src = PC_SRC_PC4;
      end
      ST_DECODE: begin
        if (f.is_j || f.is_jal) begin
          c.pc_wr  = 1'b1;
          c.pc_src = PC_SRC_JMP;
        end else if (!f.legal) begin
          c.illegal_op = 1'b1;
        end
      end
      ST_EXEC: begin
        c.alu_op    = f.alu_op;
        c.alu_src_b = f.alu_src_b;
        c.ext_op    = f.ext_op;
        c.branch_eq = f.is_beq;
        c.branch_ne = f.is_bne;
        if (f.is_beq || f.is_bne) c.pc_src = PC_SRC_BR;
      end
      ST_MEM: begin
        c.mem_rd = f.is_lw;
        c.mem_wr = f.is_sw;
      end
      ST_WB: begin
        c.reg_wr     = 1'b1;
        c.mem_to_reg = f.is_lw;
        c.reg_dst    = f.is_r ? REG_DST_RD : (f.is_jal ? REG_DST_RA : REG_DST_RT);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_ctr_if.sv
// Bundle between the control sequencer (master) and the datapath/memory side (slave).
// Pure wiring, no latency.
// mem_ready is the only backpressure; it stalls the sequencer in FETCH and MEM.
interface multi_cycle_ctr_if #(parameter int CNT_W = 32);
  logic [5:0]       op;
  logic             mem_ready;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_wr;
  logic             pc_wr;
  logic [1:0]       pc_src;
  logic             branch_eq;
  logic             branch_ne;
  logic             alu_src_b;
  logic [3:0]       alu_op;
  logic             ext_op;
  logic [1:0]       reg_dst;
  logic             mem_to_reg;
  logic             reg_wr;
  logic             illegal_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, mem_ready,
    output mem_rd, mem_wr, ir_wr, pc_wr, pc_src, branch_eq, branch_ne, alu_src_b,
           alu_op, ext_op, reg_dst, mem_to_reg, reg_wr, illegal_op, state, instr_cnt
  );

  modport slave (
    output op, mem_ready,
    input  mem_rd, mem_wr, ir_wr, pc_wr, pc_src, branch_eq, branch_ne, alu_src_b,
           alu_op, ext_op, reg_dst, mem_to_reg, reg_wr, illegal_op, state, instr_cnt
  );
endinterface

// File: rtl/mcc_op_decode.sv
// Opcode to per-instruction flags, ALU function, extension mode and ALU B-source.
// Combinational, zero latency.
// No handshake; unsupported opcodes leave every flag clear, including legal.
module mcc_op_decode
  import mcc_pkg::*;
(
  input  logic [5:0] op_i,
  output op_flags_t  flags_o
);

  // Table decode; anything not listed is illegal.
  always_comb begin
    flags_o = '0;
    case (op_i)
      OP_R:    begin flags_o.is_r = 1'b1; flags_o.alu_op = ALU_R; end
      OP_ADDI: begin flags_o.alu_op = ALU_ADDI; flags_o.ext_op = 1'b1; flags_o.alu_src_b = 1'b1; end
      OP_ANDI: begin flags_o.alu_op = ALU_ANDI; flags_o.alu_src_b = 1'b1; end
      OP_ORI:  begin flags_o.alu_op = ALU_ORI;  flags_o.alu_src_b = 1'b1; end
      OP_XORI: begin flags_o.alu_op = ALU_XORI; flags_o.alu_src_b = 1'b1; end
      OP_LUI:  begin flags_o.alu_op = ALU_LUI;  flags_o.alu_src_b = 1'b1; end
      OP_LW:   begin flags_o.is_lw = 1'b1; flags_o.alu_op = ALU_MEM; flags_o.ext_op = 1'b1; flags_o.alu_src_b = 1'b1; end
      OP_SW:   begin flags_o.is_sw = 1'b1; flags_o.alu_op = ALU_MEM; flags_o.ext_op = 1'b1; flags_o.alu_src_b = 1'b1; end
      OP_BEQ:  begin flags_o.is_beq = 1'b1; flags_o.alu_op = ALU_BR; flags_o.ext_op = 1'b1; end
      OP_BNE:  begin flags_o.is_bne = 1'b1; flags_o.alu_op = ALU_BR; flags_o.ext_op = 1'b1; end
      OP_J:    begin flags_o.is_j = 1'b1;   flags_o.alu_op = ALU_JMP; end
      OP_JAL:  begin flags_o.is_jal = 1'b1; flags_o.alu_op = ALU_JMP; end
      default: ;
    endcase
    flags_o.legal = (op_i == OP_R)    || (op_i == OP_ADDI) || (op_i == OP_ANDI) ||
                    (op_i == OP_ORI)  || (op_i == OP_XORI) || (op_i == OP_LUI)  ||
                    (op_i == OP_LW)   || (op_i == OP_SW)   || (op_i == OP_BEQ)  ||
                    (op_i == OP_BNE)  || (op_i == OP_J)    || (op_i == OP_JAL);
  end

endmodule

// File: rtl/multi_cycle_ctr.sv
// Five-state FETCH/DECODE/EXEC/MEM/WB control sequencer with retired-instruction counter.
// 2 cycles j/jal/illegal, 3 beq/bne, 4 R/imm/sw, 5 lw; MCC_JAL_LINK_EN makes jal 3 cycles (link write in WB).
// Stalls in FETCH/MEM while mem_ready=0 with outputs held; mem_ready ignored in other states.
module multi_cycle_ctr
  import mcc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_cycle_ctr_if.master bus
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;
  op_flags_t        flags_q, flags_d;
  logic             retire;

  // Current-instruction flags steer transitions; next-instruction flags feed the output register.
  mcc_op_decode u_dec_q (.op_i(op_q), .flags_o(flags_q));
  mcc_op_decode u_dec_d (.op_i(op_d), .flags_o(flags_d));

  // Transition flags are a subset; the remaining fields only matter for the output decode.
  logic unused_flags;
  assign unused_flags = ^{flags_q.is_r, flags_q.alu_op, flags_q.ext_op, flags_q.alu_src_b};

  // Next state, op latch on DECODE entry, retire pulse and next registered control word.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
          op_d    = bus.op;
        end
      end
      ST_DECODE: begin
        if (flags_q.is_j) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else if (flags_q.is_jal) begin
`ifdef MCC_JAL_LINK_EN
          state_d = ST_WB;
`else
          state_d = ST_FETCH;
          retire  = 1'b1;
`endif
        end else if (!flags_q.legal) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (flags_q.is_beq || flags_q.is_bne) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else if (flags_q.is_lw || flags_q.is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (flags_q.is_lw) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    ctl_d = ctl_decode(state_d, flags_d);
  end

  // State, opcode, counter and control word registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      ctl_q   <= ctl_decode(ST_FETCH, '0);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  // IR/PC load in FETCH happens only on the cycle the fetch completes.
  logic fetch_done;
  assign fetch_done = (state_q != ST_FETCH) || bus.mem_ready;

  // Everything reads zero while reset is held, so an aborted instruction writes nothing.
  assign bus.mem_rd     = rst_n & ctl_q.mem_rd;
  assign bus.mem_wr     = rst_n & ctl_q.mem_wr;
  assign bus.ir_wr      = rst_n & ctl_q.ir_wr & bus.mem_ready;
  assign bus.pc_wr      = rst_n & ctl_q.pc_wr & fetch_done;
  assign bus.pc_src     = rst_n ? ctl_q.pc_src : 2'b00;
  assign bus.branch_eq  = rst_n & ctl_q.branch_eq;
  assign bus.branch_ne  = rst_n & ctl_q.branch_ne;
  assign bus.alu_src_b  = rst_n & ctl_q.alu_src_b;
  assign bus.alu_op     = rst_n ? ctl_q.alu_op : 4'b0000;
  assign bus.ext_op     = rst_n & ctl_q.ext_op;
  assign bus.reg_dst    = rst_n ? ctl_q.reg_dst : 2'b00;
  assign bus.mem_to_reg = rst_n & ctl_q.mem_to_reg;
  assign bus.reg_wr     = rst_n & ctl_q.reg_wr;
  assign bus.illegal_op = rst_n & ctl_q.illegal_op;
  assign bus.state      = rst_n ? state_q : 3'd0;
  assign bus.instr_cnt  = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Directed bench for multi_cycle_ctr: stimulus pushes per-cycle expected outputs into a queue,
// a negedge monitor pops and compares; a second 2-bit-counter instance exercises counter wrap.
module tb_multi_cycle_ctr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_ctr_if #(.CNT_W(32)) ifc ();
  multi_cycle_ctr_if #(.CNT_W(2))  ifc2 ();

  multi_cycle_ctr #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(ifc));
  multi_cycle_ctr #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst2_n), .bus(ifc2));

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        branch_eq;
    logic        branch_ne;
    logic        alu_src_b;
    logic [3:0]  alu_op;
    logic        ext_op;
    logic [1:0]  reg_dst;
    logic        mem_to_reg;
    logic        reg_wr;
    logic        illegal_op;
    logic [31:0] cnt;
  } obs_t;

  typedef struct { string tag; obs_t v; } exp_rec_t;
  typedef struct { string tag; logic [2:0] st; logic [1:0] cnt; } exp2_rec_t;

  exp_rec_t  q [$];
  exp2_rec_t q2 [$];
  int checks = 0;
  int failures = 0;
  logic [31:0] ec;

  // Expected-value builders, one per kind of cycle.
  function automatic obs_t e_zero();
    obs_t o; o = '0; return o;
  endfunction
  function automatic obs_t e_fetch(logic rdy, logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd0; o.mem_rd = 1'b1; o.ir_wr = rdy; o.pc_wr = rdy; o.cnt = c; return o;
  endfunction
  function automatic obs_t e_dec(logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd1; o.cnt = c; return o;
  endfunction
  function automatic obs_t e_jmp(logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd1; o.pc_wr = 1'b1; o.pc_src = 2'd2; o.cnt = c; return o;
  endfunction
  function automatic obs_t e_ill(logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd1; o.illegal_op = 1'b1; o.cnt = c; return o;
  endfunction
  function automatic obs_t e_exec(logic [3:0] alu, logic srcb, logic ext, logic beq, logic bne,
                                  logic [1:0] psrc, logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd2; o.alu_op = alu; o.alu_src_b = srcb; o.ext_op = ext;
    o.branch_eq = beq; o.branch_ne = bne; o.pc_src = psrc; o.cnt = c; return o;
  endfunction
  function automatic obs_t e_mem(logic rd, logic wr, logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd3; o.mem_rd = rd; o.mem_wr = wr; o.cnt = c; return o;
  endfunction
  function automatic obs_t e_wb(logic [1:0] dst, logic m2r, logic [31:0] c);
    obs_t o; o = '0; o.state = 3'd4; o.reg_wr = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r; o.cnt = c; return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state = ifc.state; o.mem_rd = ifc.mem_rd; o.mem_wr = ifc.mem_wr; o.ir_wr = ifc.ir_wr;
    o.pc_wr = ifc.pc_wr; o.pc_src = ifc.pc_src; o.branch_eq = ifc.branch_eq; o.branch_ne = ifc.branch_ne;
    o.alu_src_b = ifc.alu_src_b; o.alu_op = ifc.alu_op; o.ext_op = ifc.ext_op; o.reg_dst = ifc.reg_dst;
    o.mem_to_reg = ifc.mem_to_reg; o.reg_wr = ifc.reg_wr; o.illegal_op = ifc.illegal_op; o.cnt = ifc.instr_cnt;
    return o;
  endfunction

  // Drive one cycle of inputs just after the edge and queue what that cycle must show.
  task automatic cyc(input logic r, input logic [5:0] o, input logic rdy, input string tag, input obs_t e);
    exp_rec_t rec;
    @(posedge clk); #1;
    rst_n = r; ifc.op = o; ifc.mem_ready = rdy;
    rec.tag = tag; rec.v = e;
    q.push_back(rec);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  exp_rec_t  mrec;
  exp2_rec_t mrec2;
  obs_t      mact;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mrec = q.pop_front();
      mact = sample();
      checks++;
      if (mact !== mrec.v) begin
        failures++;
        $display("FAIL %s: got %h want %h (cnt got %0d want %0d)", mrec.tag, mact, mrec.v, mact.cnt, mrec.v.cnt);
      end
    end
    if (q2.size() > 0) begin
      mrec2 = q2.pop_front();
      checks++;
      if (ifc2.state !== mrec2.st || ifc2.instr_cnt !== mrec2.cnt) begin
        failures++;
        $display("FAIL %s: got state=%0d cnt=%0d want state=%0d cnt=%0d",
                 mrec2.tag, ifc2.state, ifc2.instr_cnt, mrec2.st, mrec2.cnt);
      end
    end
  end

  // Counter wrap on a 2-bit instance: back-to-back j, two cycles each.
  logic [1:0] wrap_cnt [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [2:0] wrap_st  [10] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
  initial begin
    exp2_rec_t r2;
    ifc2.op = 6'b000010;
    ifc2.mem_ready = 1'b1;
    @(posedge clk); #1;
    rst2_n = 1'b0;
    r2.tag = "wrap.rst"; r2.st = 3'd0; r2.cnt = 2'd0; q2.push_back(r2);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      rst2_n = 1'b1;
      r2.tag = $sformatf("wrap.c%0d", k); r2.st = wrap_st[k]; r2.cnt = wrap_cnt[k];
      q2.push_back(r2);
    end
    @(posedge clk); #1;
    rst2_n = 1'b0;
  end

  initial begin
    ifc.op = 6'b000000;
    ifc.mem_ready = 1'b1;
    ec = 0;

    cyc(0, 6'b000000, 1, "rst0", e_zero());
    cyc(0, 6'b000000, 1, "rst1", e_zero());

    // R-type
    cyc(1, 6'b000000, 1, "R.fetch", e_fetch(1, ec));
    cyc(1, 6'b000000, 1, "R.dec",   e_dec(ec));
    cyc(1, 6'b000000, 1, "R.exec",  e_exec(4'b1111, 0, 0, 0, 0, 2'd0, ec));
    cyc(1, 6'b000000, 1, "R.wb",    e_wb(2'd1, 0, ec));
    ec = ec + 1;

    // lw with two MEM wait states
    cyc(1, 6'b100011, 1, "lw.fetch", e_fetch(1, ec));
    cyc(1, 6'b100011, 1, "lw.dec",   e_dec(ec));
    cyc(1, 6'b100011, 1, "lw.exec",  e_exec(4'b0001, 1, 1, 0, 0, 2'd0, ec));
    cyc(1, 6'b100011, 0, "lw.mem0",  e_mem(1, 0, ec));
    cyc(1, 6'b100011, 0, "lw.mem1",  e_mem(1, 0, ec));
    cyc(1, 6'b100011, 1, "lw.mem2",  e_mem(1, 0, ec));
    cyc(1, 6'b100011, 1, "lw.wb",    e_wb(2'd0, 1, ec));
    ec = ec + 1;

    // beq
    cyc(1, 6'b000100, 1, "beq.fetch", e_fetch(1, ec));
    cyc(1, 6'b000100, 1, "beq.dec",   e_dec(ec));
    cyc(1, 6'b000100, 1, "beq.exec",  e_exec(4'b0101, 0, 1, 1, 0, 2'd1, ec));
    ec = ec + 1;

    // bne, mem_ready low where it must be ignored
    cyc(1, 6'b000101, 1, "bne.fetch", e_fetch(1, ec));
    cyc(1, 6'b000101, 0, "bne.dec",   e_dec(ec));
    cyc(1, 6'b000101, 0, "bne.exec",  e_exec(4'b0101, 0, 1, 0, 1, 2'd1, ec));
    ec = ec + 1;

    // jal
`ifdef MCC_JAL_LINK_EN
    cyc(1, 6'b000011, 1, "jal.fetch", e_fetch(1, ec));
    cyc(1, 6'b000011, 1, "jal.dec",   e_jmp(ec));
    cyc(1, 6'b000011, 1, "jal.wb",    e_wb(2'd2, 0, ec));
    ec = ec + 1;
`else
    cyc(1, 6'b000011, 1, "jal.fetch", e_fetch(1, ec));
    cyc(1, 6'b000011, 1, "jal.dec",   e_jmp(ec));
    ec = ec + 1;
`endif

    // j
    cyc(1, 6'b000010, 1, "j.fetch", e_fetch(1, ec));
    cyc(1, 6'b000010, 1, "j.dec",   e_jmp(ec));
    ec = ec + 1;

    // illegal opcode: pulse, no retire
    cyc(1, 6'b111111, 1, "ill.fetch", e_fetch(1, ec));
    cyc(1, 6'b111111, 1, "ill.dec",   e_ill(ec));

    // sw with one FETCH wait state
    cyc(1, 6'b101011, 0, "sw.fetch0", e_fetch(0, ec));
    cyc(1, 6'b101011, 1, "sw.fetch1", e_fetch(1, ec));
    cyc(1, 6'b101011, 1, "sw.dec",    e_dec(ec));
    cyc(1, 6'b101011, 1, "sw.exec",   e_exec(4'b0001, 1, 1, 0, 0, 2'd0, ec));
    cyc(1, 6'b101011, 1, "sw.mem",    e_mem(0, 1, ec));
    ec = ec + 1;

    // ori: zero-extended immediate
    cyc(1, 6'b001101, 1, "ori.fetch", e_fetch(1, ec));
    cyc(1, 6'b001101, 1, "ori.dec",   e_dec(ec));
    cyc(1, 6'b001101, 1, "ori.exec",  e_exec(4'b0011, 1, 0, 0, 0, 2'd0, ec));
    cyc(1, 6'b001101, 1, "ori.wb",    e_wb(2'd0, 0, ec));
    ec = ec + 1;

    // sw aborted by reset while stalled in MEM
    cyc(1, 6'b101011, 1, "swr.fetch", e_fetch(1, ec));
    cyc(1, 6'b101011, 1, "swr.dec",   e_dec(ec));
    cyc(1, 6'b101011, 1, "swr.exec",  e_exec(4'b0001, 1, 1, 0, 0, 2'd0, ec));
    cyc(1, 6'b101011, 0, "swr.mem",   e_mem(0, 1, ec));
    cyc(0, 6'b101011, 0, "swr.rst",   e_zero());
    ec = 0;
    cyc(1, 6'b000010, 1, "post.fetch", e_fetch(1, ec));
    cyc(1, 6'b000010, 1, "post.dec",   e_jmp(ec));
    ec = ec + 1;
    cyc(1, 6'b000000, 1, "post.cnt",   e_fetch(1, ec));

    for (int i = 0; i < 50 && (q.size() > 0 || q2.size() > 0); i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q.size(), q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
